// File: rtl/fu_load_buffer.sv
// rtl/fu_load_buffer.sv - non-blocking load unit with store forwarding and tagged cache access
// Entries move FREE->SQ->MEM->WAIT->DONE; the lowest-index entry wins each shared port.
module fu_load_buffer #(
  parameter int XLEN     = 32,
  parameter int LB_DEPTH = 4,
  parameter int ROB_W    = 5,
  parameter int PRS_W    = 6,
  parameter int SQ_W     = 3,
  localparam int IDX_W   = $clog2(LB_DEPTH),
  localparam int NB      = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [XLEN-1:0]  issue_base,
  input  logic [XLEN-1:0]  issue_imm,
  input  logic [2:0]       issue_funct3,
  input  logic [ROB_W-1:0] issue_rob,
  input  logic [PRS_W-1:0] issue_prs,
  input  logic [SQ_W-1:0]  issue_sq_tail,
  input  logic             flush,
  output logic             sq_req_valid,
  output logic [XLEN-1:0]  sq_req_addr,
  output logic [SQ_W-1:0]  sq_req_tail,
  input  logic             sq_resp_stall,
  input  logic [NB-1:0]    sq_resp_bytes,
  input  logic [XLEN-1:0]  sq_resp_data,
  output logic             dc_req_valid,
  output logic [XLEN-1:0]  dc_req_addr,
  output logic [IDX_W-1:0] dc_req_tag,
  input  logic             dc_req_ready,
  input  logic             dc_resp_valid,
  input  logic [IDX_W-1:0] dc_resp_tag,
  input  logic [XLEN-1:0]  dc_resp_data,
  output logic             cmp_valid,
  input  logic             cmp_ready,
  output logic [ROB_W-1:0] cmp_rob,
  output logic [PRS_W-1:0] cmp_prs,
  output logic [XLEN-1:0]  cmp_data,
  output logic             cmp_misaligned
);
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {S_FREE, S_SQ, S_MEM, S_WAIT, S_DONE, S_ZOMBIE} lb_state_e;

  lb_state_e        st_q   [LB_DEPTH], st_d   [LB_DEPTH];
  logic [XLEN-1:0]  addr_q [LB_DEPTH], addr_d [LB_DEPTH];
  logic [2:0]       f3_q   [LB_DEPTH], f3_d   [LB_DEPTH];
  logic [ROB_W-1:0] rob_q  [LB_DEPTH], rob_d  [LB_DEPTH];
  logic [PRS_W-1:0] prs_q  [LB_DEPTH], prs_d  [LB_DEPTH];
  logic [SQ_W-1:0]  sqt_q  [LB_DEPTH], sqt_d  [LB_DEPTH];
  logic [NB-1:0]    fwdb_q [LB_DEPTH], fwdb_d [LB_DEPTH];
  logic [XLEN-1:0]  data_q [LB_DEPTH], data_d [LB_DEPTH];
  logic             mis_q  [LB_DEPTH], mis_d  [LB_DEPTH];

  logic             free_hit, sq_hit, mem_hit, done_hit;
  logic [IDX_W-1:0] free_idx, sq_idx, mem_idx, done_idx;
  logic [LB_DEPTH-1:0] resp_hit;
  logic [XLEN-1:0]  issue_addr;

  function automatic logic [NB-1:0] use_bytes(input logic [2:0] f3, input logic [OFF_W-1:0] off);
    case (f3)
      3'b000, 3'b100: use_bytes = NB'(1) << off;
      3'b001, 3'b101: use_bytes = NB'(3) << (off & ~OFF_W'(1));
      default:        use_bytes = NB'(15) << (off & ~OFF_W'(3));
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [OFF_W-1:0] off);
    case (f3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = off[0];
      default:        misaligned = (off[1:0] != 2'b00);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] format_load(input logic [2:0] f3, input logic [OFF_W-1:0] off,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] sh;
    sh = d >> {off, 3'b000};
    case (f3)
      3'b000:  format_load = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b100:  format_load = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b001:  format_load = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b101:  format_load = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: format_load = sh;
    endcase
  endfunction

  assign issue_addr = issue_base + issue_imm;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    free_hit = 1'b0; sq_hit = 1'b0; mem_hit = 1'b0; done_hit = 1'b0;
    free_idx = '0;   sq_idx = '0;   mem_idx = '0;   done_idx = '0;
    for (int i = LB_DEPTH - 1; i >= 0; i--) begin
      if (st_q[i] == S_FREE) begin free_hit = 1'b1; free_idx = IDX_W'(i); end
      if (st_q[i] == S_SQ)   begin sq_hit   = 1'b1; sq_idx   = IDX_W'(i); end
      if (st_q[i] == S_MEM)  begin mem_hit  = 1'b1; mem_idx  = IDX_W'(i); end
      if (st_q[i] == S_DONE) begin done_hit = 1'b1; done_idx = IDX_W'(i); end
    end
  end

  assign issue_ready    = free_hit;
  assign sq_req_valid   = sq_hit;
  assign sq_req_addr    = sq_hit ? (addr_q[sq_idx] & ~XLEN'(NB - 1)) : '0;
  assign sq_req_tail    = sq_hit ? sqt_q[sq_idx] : '0;
  assign dc_req_valid   = mem_hit;
  assign dc_req_addr    = mem_hit ? (addr_q[mem_idx] & ~XLEN'(NB - 1)) : '0;
  assign dc_req_tag     = mem_hit ? mem_idx : '0;
  assign cmp_valid      = done_hit;
  assign cmp_rob        = done_hit ? rob_q[done_idx] : '0;
  assign cmp_prs        = done_hit ? prs_q[done_idx] : '0;
  assign cmp_misaligned = done_hit ? mis_q[done_idx] : 1'b0;
  assign cmp_data       = done_hit ? format_load(f3_q[done_idx], addr_q[done_idx][OFF_W-1:0], data_q[done_idx]) : '0;

  always_comb begin
    resp_hit = '0;
    for (int i = 0; i < LB_DEPTH; i++) begin
      resp_hit[i] = dc_resp_valid && (dc_resp_tag == IDX_W'(i));
      st_d[i] = st_q[i]; addr_d[i] = addr_q[i]; f3_d[i] = f3_q[i]; rob_d[i] = rob_q[i];
      prs_d[i] = prs_q[i]; sqt_d[i] = sqt_q[i]; fwdb_d[i] = fwdb_q[i]; data_d[i] = data_q[i];
      mis_d[i] = mis_q[i];
      case (st_q[i])
        S_SQ: if (sq_idx == IDX_W'(i) && !sq_resp_stall) begin
          fwdb_d[i] = sq_resp_bytes;
          data_d[i] = sq_resp_data;
          st_d[i] = ((use_bytes(f3_q[i], addr_q[i][OFF_W-1:0]) & ~sq_resp_bytes) == '0) ? S_DONE : S_MEM;
        end
        S_MEM: if (mem_idx == IDX_W'(i) && dc_req_ready) st_d[i] = S_WAIT;
        S_WAIT: if (resp_hit[i]) begin
          for (int b = 0; b < NB; b++)
            if (!fwdb_q[i][b]) data_d[i][8*b +: 8] = dc_resp_data[8*b +: 8];
          st_d[i] = S_DONE;
        end
        S_DONE: if (done_idx == IDX_W'(i) && cmp_ready) st_d[i] = S_FREE;
        S_ZOMBIE: if (resp_hit[i]) st_d[i] = S_FREE;
        default: ;
      endcase
      // Outstanding cache requests must drain before the tag can be reused.
      if (flush) begin
        if ((st_q[i] == S_WAIT || st_q[i] == S_ZOMBIE) && !resp_hit[i]) st_d[i] = S_ZOMBIE;
        else st_d[i] = S_FREE;
      end else if (issue_valid && free_hit && free_idx == IDX_W'(i)) begin
        addr_d[i] = issue_addr;
        f3_d[i]   = issue_funct3;
        rob_d[i]  = issue_rob;
        prs_d[i]  = issue_prs;
        sqt_d[i]  = issue_sq_tail;
        fwdb_d[i] = '0;
        data_d[i] = '0;
        mis_d[i]  = misaligned(issue_funct3, issue_addr[OFF_W-1:0]);
        st_d[i]   = mis_d[i] ? S_DONE : S_SQ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LB_DEPTH; i++) begin
        st_q[i] <= S_FREE; addr_q[i] <= '0; f3_q[i] <= '0; rob_q[i] <= '0; prs_q[i] <= '0;
        sqt_q[i] <= '0; fwdb_q[i] <= '0; data_q[i] <= '0; mis_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LB_DEPTH; i++) begin
        st_q[i] <= st_d[i]; addr_q[i] <= addr_d[i]; f3_q[i] <= f3_d[i]; rob_q[i] <= rob_d[i];
        prs_q[i] <= prs_d[i]; sqt_q[i] <= sqt_d[i]; fwdb_q[i] <= fwdb_d[i]; data_q[i] <= data_d[i];
        mis_q[i] <= mis_d[i];
      end
    end
  end
endmodule

// File: tb/tb_fu_load_buffer.sv
// tb/tb_fu_load_buffer.sv - directed self-checking bench for fu_load_buffer
module tb_fu_load_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_base, issue_imm;
  logic [2:0]  issue_funct3;
  logic [4:0]  issue_rob;
  logic [5:0]  issue_prs;
  logic [2:0]  issue_sq_tail;
  logic        flush;
  logic        sq_req_valid;
  logic [31:0] sq_req_addr;
  logic [2:0]  sq_req_tail;
  logic        sq_resp_stall;
  logic [3:0]  sq_resp_bytes;
  logic [31:0] sq_resp_data;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  logic [1:0]  dc_req_tag;
  logic        dc_req_ready;
  logic        dc_resp_valid;
  logic [1:0]  dc_resp_tag;
  logic [31:0] dc_resp_data;
  logic        cmp_valid, cmp_ready;
  logic [4:0]  cmp_rob;
  logic [5:0]  cmp_prs;
  logic [31:0] cmp_data;
  logic        cmp_misaligned;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fu_load_buffer #(.XLEN(32), .LB_DEPTH(4), .ROB_W(5), .PRS_W(6), .SQ_W(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_base(issue_base),
    .issue_imm(issue_imm), .issue_funct3(issue_funct3), .issue_rob(issue_rob),
    .issue_prs(issue_prs), .issue_sq_tail(issue_sq_tail), .flush(flush),
    .sq_req_valid(sq_req_valid), .sq_req_addr(sq_req_addr), .sq_req_tail(sq_req_tail),
    .sq_resp_stall(sq_resp_stall), .sq_resp_bytes(sq_resp_bytes), .sq_resp_data(sq_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag),
    .dc_req_ready(dc_req_ready), .dc_resp_valid(dc_resp_valid), .dc_resp_tag(dc_resp_tag),
    .dc_resp_data(dc_resp_data), .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
    .cmp_rob(cmp_rob), .cmp_prs(cmp_prs), .cmp_data(cmp_data), .cmp_misaligned(cmp_misaligned)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] base, input logic [31:0] imm, input logic [2:0] f3,
                       input logic [4:0] rob, input logic [5:0] prs);
    issue_valid = 1'b1; issue_base = base; issue_imm = imm; issue_funct3 = f3;
    issue_rob = rob; issue_prs = prs; issue_sq_tail = rob[2:0];
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic respond(input logic [1:0] tag, input logic [31:0] data);
    dc_resp_valid = 1'b1; dc_resp_tag = tag; dc_resp_data = data;
    @(negedge clk);
    dc_resp_valid = 1'b0;
  endtask

  initial begin
    int order[4] = '{2, 0, 3, 1};
    rst = 1'b1; issue_valid = 1'b0; issue_base = '0; issue_imm = '0; issue_funct3 = '0;
    issue_rob = '0; issue_prs = '0; issue_sq_tail = '0; flush = 1'b0; sq_resp_stall = 1'b0;
    sq_resp_bytes = '0; sq_resp_data = '0; dc_req_ready = 1'b1; dc_resp_valid = 1'b0;
    dc_resp_tag = '0; dc_resp_data = '0; cmp_ready = 1'b1;
    #2;
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_sq_valid", 32'(sq_req_valid), 32'd0);
    check("rst_dc_valid", 32'(dc_req_valid), 32'd0);
    check("rst_dc_tag", 32'(dc_req_tag), 32'd0);
    check("rst_cmp_valid", 32'(cmp_valid), 32'd0);
    check("rst_cmp_mis", 32'(cmp_misaligned), 32'd0);
    check("rst_cmp_data", cmp_data, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // LW through the cache
    issue(32'h100, 32'h4, 3'b010, 5'd5, 6'd17);
    check("lw_sq_valid", 32'(sq_req_valid), 32'd1);
    check("lw_sq_addr", sq_req_addr, 32'h104);
    check("lw_sq_tail", 32'(sq_req_tail), 32'd5);
    check("lw_dc_early", 32'(dc_req_valid), 32'd0);
    cyc();
    check("lw_dc_valid", 32'(dc_req_valid), 32'd1);
    check("lw_dc_addr", dc_req_addr, 32'h104);
    check("lw_dc_tag", 32'(dc_req_tag), 32'd0);
    check("lw_cmp_early", 32'(cmp_valid), 32'd0);
    cyc();
    check("lw_cmp_c3", 32'(cmp_valid), 32'd0);
    respond(2'd0, 32'hDEADBEEF);
    check("lw_cmp_valid", 32'(cmp_valid), 32'd1);
    check("lw_cmp_data", cmp_data, 32'hDEADBEEF);
    check("lw_cmp_rob", 32'(cmp_rob), 32'd5);
    check("lw_cmp_prs", 32'(cmp_prs), 32'd17);
    check("lw_cmp_mis", 32'(cmp_misaligned), 32'd0);
    cyc();
    check("lw_cmp_done", 32'(cmp_valid), 32'd0);
    check("lw_issue_ready", 32'(issue_ready), 32'd1);

    // LB fully forwarded, then LBU with one stall cycle
    sq_resp_bytes = 4'b1000; sq_resp_data = 32'h80000000;
    issue(32'h200, 32'h3, 3'b000, 5'd6, 6'd20);
    check("lb_sq_addr", sq_req_addr, 32'h200);
    cyc();
    check("lb_cmp_valid", 32'(cmp_valid), 32'd1);
    check("lb_cmp_data", cmp_data, 32'hFFFFFF80);
    check("lb_no_dc", 32'(dc_req_valid), 32'd0);
    cyc();
    sq_resp_stall = 1'b1;
    issue(32'h200, 32'h3, 3'b100, 5'd7, 6'd21);
    cyc();
    check("lbu_stall_sq", 32'(sq_req_valid), 32'd1);
    check("lbu_stall_cmp", 32'(cmp_valid), 32'd0);
    sq_resp_stall = 1'b0;
    cyc();
    check("lbu_cmp_valid", 32'(cmp_valid), 32'd1);
    check("lbu_cmp_data", cmp_data, 32'h00000080);
    check("lbu_no_dc", 32'(dc_req_valid), 32'd0);
    cyc();

    // LH with one forwarded byte merged with cache data
    sq_resp_bytes = 4'b0100; sq_resp_data = 32'h00AA0000;
    issue(32'h100, 32'h2, 3'b001, 5'd8, 6'd22);
    check("lh_sq_addr", sq_req_addr, 32'h100);
    cyc();
    check("lh_dc_valid", 32'(dc_req_valid), 32'd1);
    check("lh_dc_addr", dc_req_addr, 32'h100);
    sq_resp_bytes = '0; sq_resp_data = '0;
    cyc();
    respond(2'd0, 32'h11223344);
    check("lh_cmp_valid", 32'(cmp_valid), 32'd1);
    check("lh_cmp_data", cmp_data, 32'h000011AA);
    cyc();

    // Fill all entries and answer out of order
    for (int i = 0; i < 4; i++) issue(32'h1000 + 32'(4 * i), 32'h0, 3'b010, 5'(10 + i), 6'(30 + i));
    check("full_issue_ready", 32'(issue_ready), 32'd0);
    check("full_dc_tag", 32'(dc_req_tag), 32'd2);
    cyc();
    cyc();
    for (int k = 0; k < 4; k++) begin
      respond(2'(order[k]), 32'hCAFE0000 + 32'(order[k]));
      check("ooo_cmp_valid", 32'(cmp_valid), 32'd1);
      check("ooo_cmp_rob", 32'(cmp_rob), 32'(10 + order[k]));
      check("ooo_cmp_data", cmp_data, 32'hCAFE0000 + 32'(order[k]));
      if (k == 0) check("ooo_still_full", 32'(issue_ready), 32'd0);
    end
    check("ooo_after_ready", 32'(issue_ready), 32'd1);
    cyc();
    check("ooo_drained", 32'(cmp_valid), 32'd0);

    // Misaligned LW, held while cmp_ready is low
    cmp_ready = 1'b0;
    issue(32'h100, 32'h2, 3'b010, 5'd3, 6'd9);
    check("mis_cmp_valid", 32'(cmp_valid), 32'd1);
    check("mis_flag", 32'(cmp_misaligned), 32'd1);
    check("mis_data", cmp_data, 32'd0);
    check("mis_no_sq", 32'(sq_req_valid), 32'd0);
    check("mis_no_dc", 32'(dc_req_valid), 32'd0);
    cyc();
    check("mis_hold_valid", 32'(cmp_valid), 32'd1);
    check("mis_hold_rob", 32'(cmp_rob), 32'd3);
    cmp_ready = 1'b1;
    cyc();
    check("mis_done", 32'(cmp_valid), 32'd0);

    // Flush with one entry in WAIT; zombie tag blocks reuse until its response
    issue(32'h300, 32'h0, 3'b010, 5'd20, 6'd40);
    issue(32'h304, 32'h0, 3'b010, 5'd21, 6'd41);
    cyc();
    check("fl_dc_tag_b", 32'(dc_req_tag), 32'd1);
    flush = 1'b1; dc_req_ready = 1'b0;
    cyc();
    flush = 1'b0;
    check("fl_cmp_valid", 32'(cmp_valid), 32'd0);
    check("fl_sq_valid", 32'(sq_req_valid), 32'd0);
    check("fl_dc_valid", 32'(dc_req_valid), 32'd0);
    check("fl_issue_ready", 32'(issue_ready), 32'd1);
    dc_req_ready = 1'b1;
    issue(32'h400, 32'h0, 3'b010, 5'd22, 6'd42);
    respond(2'd0, 32'h55555555);
    check("fl_zombie_cmp", 32'(cmp_valid), 32'd0);
    check("fl_c_dc_tag", 32'(dc_req_tag), 32'd1);
    issue(32'h500, 32'h0, 3'b010, 5'd23, 6'd43);
    check("fl_cmp_c7", 32'(cmp_valid), 32'd0);
    cyc();
    check("fl_d_dc_tag", 32'(dc_req_tag), 32'd0);
    respond(2'd1, 32'hC0C0C0C0);
    check("fl_c_rob", 32'(cmp_rob), 32'd22);
    check("fl_c_data", cmp_data, 32'hC0C0C0C0);
    respond(2'd0, 32'hD0D0D0D0);
    check("fl_d_rob", 32'(cmp_rob), 32'd23);
    check("fl_d_data", cmp_data, 32'hD0D0D0D0);
    cyc();
    check("fl_end_ready", 32'(issue_ready), 32'd1);
    check("fl_end_cmp", 32'(cmp_valid), 32'd0);

    // Reset mid-operation drops a WAIT entry; its late response is ignored
    issue(32'h600, 32'h0, 3'b010, 5'd1, 6'd1);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    check("mrst_ready", 32'(issue_ready), 32'd1);
    check("mrst_cmp", 32'(cmp_valid), 32'd0);
    rst = 1'b0;
    respond(2'd0, 32'h12345678);
    check("mrst_late_resp", 32'(cmp_valid), 32'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fu_load_buffer.md
# fu_load_buffer

Non-blocking load functional unit that holds up to `LB_DEPTH` loads in flight at once. It sits between the load reservation-station issue port and the complete stage. Each entry independently performs address generation, store-queue forwarding lookup, tagged data-cache access, byte merge, alignment/extension and completion arbitration. Misaligned loads are detected and completed with an exception flag instead of touching memory. Pipeline squash is supported, including entries whose cache response is still outstanding.

## Interface
Parameters:
- `XLEN`, 32, data/address width (multiple of 32; byte lanes = XLEN/8 = 4 at default)
- `LB_DEPTH`, 4, number of load entries (power of two, ≥2); `IDX_W` = log2(LB_DEPTH)
- `ROB_W`, 5, ROB index width; `PRS_W`, 6, physical register width; `SQ_W`, 3, store-queue index width

Ports:
- `clk` in 1, sole clock; `rst` in 1, asynchronous active-high reset
- `issue_valid` in 1; `issue_ready` out 1, high when any entry is FREE; the transfer occurs when both are high
- `issue_base` in XLEN, `issue_imm` in XLEN (sign-extended I-imm), `issue_funct3` in 3 (LB=000, LH=001, LW=010, LBU=100, LHU=101), `issue_rob` in ROB_W, `issue_prs` in PRS_W, `issue_sq_tail` in SQ_W
- `flush` in 1, squash all loads
- `sq_req_valid` out 1, `sq_req_addr` out XLEN (word-aligned), `sq_req_tail` out SQ_W
- `sq_resp_stall` in 1, `sq_resp_bytes` in 4, `sq_resp_data` in XLEN; all combinational in the same cycle as the request
- `dc_req_valid` out 1, `dc_req_addr` out XLEN (word-aligned), `dc_req_tag` out IDX_W, `dc_req_ready` in 1
- `dc_resp_valid` in 1, `dc_resp_tag` in IDX_W, `dc_resp_data` in XLEN
- `cmp_valid` out 1, `cmp_ready` in 1, `cmp_rob` out ROB_W, `cmp_prs` out PRS_W, `cmp_data` out XLEN, `cmp_misaligned` out 1

## Operation
- Entry states: FREE, SQ, MEM, WAIT, DONE, ZOMBIE.
- Allocation: an issue handshake writes the lowest-index FREE entry. addr = base+imm (mod 2^XLEN). usebytes: LB/LBU = 1<<addr[1:0]; LH/LHU = addr[1] ? 1100 : 0011; LW = 1111.
- Misalignment: LH/LHU with addr[0]=1, or LW with addr[1:0]≠0, go straight to DONE with misaligned=1 and data 0.
- Other loads go to SQ.
- Undefined funct3 values are treated as LW.
- SQ stage: the lowest-index SQ entry drives the SQ port.
  - `sq_resp_stall` = 1: the entry stays in SQ.
  - Otherwise the entry latches fwd_bytes and fwd_data.
  - If (usebytes & ~fwd_bytes) = 0, the entry goes to DONE; else it goes to MEM.
- MEM stage: the lowest-index MEM entry drives `dc_req_*` with tag = its index. On `dc_req_ready` it goes to WAIT; otherwise it stays in MEM.
- WAIT: `dc_resp_valid` with matching tag merges the data. Each byte lane i takes fwd_data when fwd_bytes[i]=1, else dc_resp_data. The entry then goes to DONE.
- Formatting (computed for cmp_data):
  - LB/LH sign-extend the selected byte/halfword.
  - LBU/LHU zero-extend it.
  - LW passes the whole word.
- Completion: the lowest-index DONE entry drives `cmp_*`. `cmp_valid` && `cmp_ready` returns the entry to FREE.
- Flush:
  - FREE/SQ/MEM/DONE entries become FREE.
  - WAIT entries become ZOMBIE.
  - A ZOMBIE entry becomes FREE on its `dc_resp` without completing.
  - An issue handshake in the flush cycle is discarded.
- A `dc_resp` with a tag whose entry is not WAIT/ZOMBIE is ignored.

## Timing
- Reset (async): all entries FREE, all data fields 0.
- Output values during reset:
  - `issue_ready`=1
  - `sq_req_valid`, `dc_req_valid`, `cmp_valid`, `cmp_misaligned` = 0
  - `cmp_*` data = 0
  - `dc_req_tag` = 0
- Reset mid-operation drops all entries, including WAIT ones. A late `dc_resp` is ignored under the tag rule.
- All state updates occur on the clk rising edge. `issue_ready`, `sq_req_*`, `dc_req_*` and `cmp_*` are decoded from registered state only, with no combinational path from any input.
- Latency from issue handshake at cycle 0, unstalled and with the unit otherwise empty:
  - Full SQ forward: `cmp_valid` in cycle 2.
  - Cache: `dc_req_valid` in cycle 2; with `dc_resp` in cycle 3, `cmp_valid` in cycle 4.
  - Misaligned: `cmp_valid` in cycle 1.
- A freed entry is allocatable from the cycle after its completion handshake.
- `issue_ready`=0 whenever all LB_DEPTH entries are non-FREE, ZOMBIE included.
- `cmp_*` is held stable while `cmp_valid` && !`cmp_ready`.
- Responses may return out of order. A `dc_resp` may coincide with a `dc_req` for a different entry.
- A `dc_resp` and `flush` in the same cycle for a WAIT entry: the entry becomes FREE.

## Test plan
- Issue LW base=0x100, imm=4, no SQ bytes; `dc_resp` data 0xDEADBEEF at cycle 3 → at cycle 4 `cmp_valid`=1, `cmp_data`=0xDEADBEEF, rob/prs echoed.
- LB addr 0x203; SQ returns bytes 1000, data 0x80000000 → `cmp_valid` cycle 2 with `cmp_data`=0xFFFFFF80 and no `dc_req`. Repeating as LBU gives 0x00000080.
- LH addr 0x102; SQ bytes 0100 with data 0x00AA0000; cache data 0x11223344 → merged halfword 0x11AA, `cmp_data`=0x000011AA.
- Fill 4 entries with `dc_req_ready`=1; return responses with tags 2,0,3,1 → `issue_ready`=0 while full. Completions arrive in response order, each with the correct data.
- LW addr 0x102 → `cmp_misaligned`=1 and `cmp_data`=0 in cycle 1, with no SQ or cache request.
- Two loads, one in WAIT, then `flush`; `dc_resp` for the WAIT tag 2 cycles later → no `cmp_valid`. `issue_ready` reflects the ZOMBIE entry until the response, then all entries are FREE.
